// File: rtl/alu_sched_pkg.sv
// Shared constants and types for the shared-ALU request scheduler.
// Opcode encodings, the datapath width and the response record layout.
// Pure declarations; no logic, latency or backpressure of its own.
package alu_sched_pkg;

  localparam int DW     = 64;
  // Widest requester id the scheduler supports (NREQ up to 8).
  localparam int IDMAXW = 3;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_RSUB = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_XNOR = 3'b110;
  localparam logic [2:0] OP_ZERO = 3'b111;

  typedef struct packed {
    logic [DW-1:0]     data;
    logic [IDMAXW-1:0] id;
    logic              err;
  } rsp_t;

endpackage

// File: rtl/mini_alu.sv
// 64-bit mini ALU: add, both subtract orders, or/and/xor/xnor, zero.
// Latency: purely combinational.
// Backpressure: none; the caller registers inputs and outputs.
module mini_alu
  import alu_sched_pkg::*;
(
  input  logic [2:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y
);

  // Select the result for the opcode; carries and borrows simply fall off the top.
  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_RSUB: y = b - a;
      OP_OR:   y = a | b;
      OP_AND:  y = a & b;
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first asserted request after ptr, wrapping.
// Latency: purely combinational grant.
// Backpressure: en=0 forces an all-zero grant.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx
);

  logic           found;
  logic [IDW-1:0] j;

  // Walk ptr+1 .. ptr+NREQ (mod NREQ) and take the first requester seen.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      j = IDW'((int'(ptr) + k) % NREQ);
      if (en && !found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/alu_rr_sched.sv
// Shares one mini ALU among NREQ requesters with round-robin grant; optional rsp_err via ALU_RR_SCHED_ERR_EN.
// Latency: accept on edge N, operands in s1 after N, response valid after N+1.
// Backpressure: s2 holds while rsp_ready=0; s1 then holds and req_ready drops to all zero.
module alu_rr_sched
  import alu_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [3*NREQ-1:0]  req_op,
  input  logic [DW*NREQ-1:0] req_a,
  input  logic [DW*NREQ-1:0] req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DW-1:0]      rsp_data,
  output logic [IDW-1:0]     rsp_id
`ifdef ALU_RR_SCHED_ERR_EN
  ,
  output logic               rsp_err
`endif
);

  logic            s1_v;
  logic [2:0]      s1_op;
  logic [DW-1:0]   s1_a;
  logic [DW-1:0]   s1_b;
  logic [IDW-1:0]  s1_id;
  logic            s2_v;
  logic            s1_free;
  logic            s2_free;
  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gidx;
  logic            accept;
  logic [2:0]      sel_op;
  logic [DW-1:0]   sel_a;
  logic [DW-1:0]   sel_b;
  logic [DW-1:0]   alu_y;

  assign s2_free   = !s2_v || rsp_ready;
  assign s1_free   = !s1_v || s2_free;
  assign req_ready = gnt;
  assign accept    = |gnt;
  assign rsp_valid = s2_v;

  // Arbiter is held off during reset so req_ready reads zero while rst is high.
  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req (req_valid),
    .ptr (ptr),
    .en  (s1_free && !rst),
    .gnt (gnt),
    .idx (gidx)
  );

  // One-hot payload mux driven by the grant vector.
  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_op = req_op[3*i +: 3];
        sel_a  = req_a[DW*i +: DW];
        sel_b  = req_b[DW*i +: DW];
      end
    end
  end

  mini_alu u_alu (
    .op (s1_op),
    .a  (s1_a),
    .b  (s1_b),
    .y  (alu_y)
  );

  // Two-stage pipeline and round-robin pointer; reset discards anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v     <= 1'b0;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
      s2_v     <= 1'b0;
      rsp_data <= '0;
      rsp_id   <= '0;
`ifdef ALU_RR_SCHED_ERR_EN
      rsp_err  <= 1'b0;
`endif
      ptr      <= IDW'(NREQ - 1);
    end else begin
      if (s2_free) begin
        s2_v <= s1_v;
        if (s1_v) begin
          rsp_data <= alu_y;
          rsp_id   <= s1_id;
`ifdef ALU_RR_SCHED_ERR_EN
          rsp_err  <= (s1_op == OP_ZERO);
`endif
        end
      end
      if (s1_free) begin
        s1_v <= accept;
        if (accept) begin
          s1_op <= sel_op;
          s1_a  <= sel_a;
          s1_b  <= sel_b;
          s1_id <= gidx;
        end
      end
      if (accept) begin
        ptr <= gidx;
      end
    end
  end

endmodule

// File: tb/tb_alu_rr_sched.sv
// Directed bench for alu_rr_sched: vector table of single requests plus
// fairness, backpressure and mid-flight reset sequences.
module tb_alu_rr_sched;
  import alu_sched_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [3*NREQ-1:0]  req_op;
  logic [DW*NREQ-1:0] req_a;
  logic [DW*NREQ-1:0] req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [DW-1:0]      rsp_data;
  logic [IDW-1:0]     rsp_id;
`ifdef ALU_RR_SCHED_ERR_EN
  logic               rsp_err;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_rr_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
`ifdef ALU_RR_SCHED_ERR_EN
    ,
    .rsp_err   (rsp_err)
`endif
  );

  typedef struct {
    int         id;
    logic [2:0] op;
    logic [63:0] a;
    logic [63:0] b;
    rsp_t       exp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    req_op[3*i +: 3] = op;
    req_a[64*i +: 64] = a;
    req_b[64*i +: 64] = b;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    set_req(v.id, v.op, v.a, v.b);
    req_valid[v.id] = 1'b1;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (req_ready[v.id]) got = 1'b1;
    end
    chk("vec_grant", {63'd0, got}, 64'd1);
    @(posedge clk); #1;
    req_valid[v.id] = 1'b0;
    @(negedge clk);
    chk("vec_lat_s1", {63'd0, rsp_valid}, 64'd0);
    @(negedge clk);
    chk("vec_lat_s2", {63'd0, rsp_valid}, 64'd1);
    chk("vec_data", rsp_data, v.exp.data);
    chk("vec_id", {62'd0, rsp_id}, {61'd0, v.exp.id});
`ifdef ALU_RR_SCHED_ERR_EN
    chk("vec_err", {63'd0, rsp_err}, {63'd0, v.exp.err});
`endif
  endtask

  initial begin
    vecs[0] = '{0, OP_ADD,  64'd5,     64'd7,     '{data:64'd12,                  id:3'd0, err:1'b0}};
    vecs[1] = '{1, OP_SUB,  64'd0,     64'd1,     '{data:64'hFFFF_FFFF_FFFF_FFFF, id:3'd1, err:1'b0}};
    vecs[2] = '{2, OP_RSUB, 64'd3,     64'd10,    '{data:64'd7,                   id:3'd2, err:1'b0}};
    vecs[3] = '{3, OP_OR,   64'hF0,    64'h0F,    '{data:64'hFF,                  id:3'd3, err:1'b0}};
    vecs[4] = '{0, OP_AND,  64'hF0F0,  64'hFF00,  '{data:64'hF000,                id:3'd0, err:1'b0}};
    vecs[5] = '{1, OP_XOR,  64'hF0,    64'hFF,    '{data:64'h0F,                  id:3'd1, err:1'b0}};
    vecs[6] = '{2, OP_XNOR, 64'd0,     64'd0,     '{data:64'hFFFF_FFFF_FFFF_FFFF, id:3'd2, err:1'b0}};
    vecs[7] = '{3, OP_ZERO, 64'd1,     64'd1,     '{data:64'd0,                   id:3'd3, err:1'b1}};
    vecs[8] = '{0, OP_XOR,  64'hF0,    64'hFF,    '{data:64'h0F,                  id:3'd0, err:1'b0}};
    vecs[9] = '{1, OP_ADD,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, '{data:64'd0,         id:3'd1, err:1'b0}};

    rst       = 1'b1;
    req_valid = '1;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;

    // Reset state, with requests asserted to show the grant is held off.
    @(negedge clk);
    chk("rst_req_ready", {60'd0, req_ready}, 64'd0);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    chk("rst_rsp_id", {62'd0, rsp_id}, 64'd0);
`ifdef ALU_RR_SCHED_ERR_EN
    chk("rst_rsp_err", {63'd0, rsp_err}, 64'd0);
`endif
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Fairness: all four requesters held, full throughput.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, OP_ADD, 64'(i), 64'd100);
    req_valid = '1;
    for (int c = 0; c < 10; c++) begin
      logic [3:0] eg;
      int eid;
      @(negedge clk);
      eg = (c < 8) ? 4'(1 << (c % 4)) : 4'd0;
      chk("fair_grant", {60'd0, req_ready}, {60'd0, eg});
      if (c >= 2) begin
        eid = (c - 2) % 4;
        chk("fair_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("fair_rsp_id", {62'd0, rsp_id}, 64'(eid));
        chk("fair_rsp_data", rsp_data, 64'(100 + eid));
      end
      @(posedge clk); #1;
      if (c == 7) req_valid = '0;
    end
    @(negedge clk);
    chk("fair_drained", {63'd0, rsp_valid}, 64'd0);

    // Backpressure: req0 (two ops) and req2 pending, consumer stalled 5 cycles.
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    set_req(0, OP_ADD, 64'd1, 64'd1);
    set_req(2, OP_SUB, 64'd10, 64'd3);
    req_valid = 4'b0101;
    @(negedge clk);
    chk("bp_grant0", {60'd0, req_ready}, 64'b0001);
    @(posedge clk); #1;
    set_req(0, OP_XOR, 64'hF0, 64'hFF);
    @(negedge clk);
    chk("bp_grant2", {60'd0, req_ready}, 64'b0100);
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    for (int d = 0; d < 5; d++) begin
      @(negedge clk);
      chk("bp_hold_valid", {63'd0, rsp_valid}, 64'd1);
      chk("bp_hold_data", rsp_data, 64'd2);
      chk("bp_hold_id", {62'd0, rsp_id}, 64'd0);
      chk("bp_full_ready", {60'd0, req_ready}, 64'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_grant", {60'd0, req_ready}, 64'b0001);
    chk("bp_rel_data0", rsp_data, 64'd2);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("bp_rel_valid1", {63'd0, rsp_valid}, 64'd1);
    chk("bp_rel_data1", rsp_data, 64'd7);
    chk("bp_rel_id1", {62'd0, rsp_id}, 64'd2);
    @(negedge clk);
    chk("bp_rel_valid2", {63'd0, rsp_valid}, 64'd1);
    chk("bp_rel_data2", rsp_data, 64'h0F);
    chk("bp_rel_id2", {62'd0, rsp_id}, 64'd0);
    @(negedge clk);
    chk("bp_rel_empty", {63'd0, rsp_valid}, 64'd0);

    // Mid-flight reset: fill both stages from requester 3, then reset.
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    set_req(3, OP_ADD, 64'd20, 64'd22);
    req_valid = 4'b1000;
    @(negedge clk);
    chk("mr_grant3a", {60'd0, req_ready}, 64'b1000);
    @(negedge clk);
    chk("mr_grant3b", {60'd0, req_ready}, 64'b1000);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("mr_full_valid", {63'd0, rsp_valid}, 64'd1);
    chk("mr_full_data", rsp_data, 64'd42);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_async_valid", {63'd0, rsp_valid}, 64'd0);
    chk("mr_async_data", rsp_data, 64'd0);
    chk("mr_async_ready", {60'd0, req_ready}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    set_req(0, OP_ADD, 64'd5, 64'd7);
    req_valid = 4'b1001;
    @(negedge clk);
    chk("mr_first_grant", {60'd0, req_ready}, 64'b0001);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("mr_second_grant", {60'd0, req_ready}, 64'b1000);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("mr_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("mr_rsp_id", {62'd0, rsp_id}, 64'd0);
    chk("mr_rsp_data", rsp_data, 64'd12);
    @(negedge clk);
    chk("mr_rsp_id3", {62'd0, rsp_id}, 64'd3);
    chk("mr_rsp_data3", rsp_data, 64'd42);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
